// File: rtl/rot_pkg.sv
// rot_pkg: shared encodings for the rotate/shift sequencer.
// Used by rot_step and rot_seq_ctrl.
package rot_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_ROR = 2'd0,
    OP_ROL = 2'd1,
    OP_SLL = 2'd2,
    OP_SRL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rot_step.sv
// rot_step: one combinational rotate/shift step of 1 or 4 bits.
// carry_out is the last single bit moved out by the step.
module rot_step
  import rot_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] value,
  input  op_e              op,
  input  logic             nib,
  output logic [WIDTH-1:0] next_value,
  output logic             carry_out
);

  // select the stepped value and the outgoing bit
  always_comb begin
    next_value = value;
    carry_out  = 1'b0;
    unique case (op)
      OP_ROR: begin
        if (nib) begin
          next_value = {value[3:0], value[WIDTH-1:4]};
          carry_out  = value[3];
        end else begin
          next_value = {value[0], value[WIDTH-1:1]};
          carry_out  = value[0];
        end
      end
      OP_ROL: begin
        if (nib) begin
          next_value = {value[WIDTH-5:0], value[WIDTH-1:WIDTH-4]};
          carry_out  = value[WIDTH-4];
        end else begin
          next_value = {value[WIDTH-2:0], value[WIDTH-1]};
          carry_out  = value[WIDTH-1];
        end
      end
      OP_SLL: begin
        if (nib) begin
          next_value = {value[WIDTH-5:0], 4'b0000};
          carry_out  = value[WIDTH-4];
        end else begin
          next_value = {value[WIDTH-2:0], 1'b0};
          carry_out  = value[WIDTH-1];
        end
      end
      OP_SRL: begin
        if (nib) begin
          next_value = {4'b0000, value[WIDTH-1:4]};
          carry_out  = value[3];
        end else begin
          next_value = {1'b0, value[WIDTH-1:1]};
          carry_out  = value[0];
        end
      end
    endcase
  end

endmodule

// File: rtl/rot_seq_ctrl.sv
// rot_seq_ctrl: multi-cycle ROR/ROL/SLL/SRL sequencer, valid/ready I/O.
// ROT_SEQ_NIBBLE_STEP_EN enables 4-bit steps while cnt >= 4.
module rot_seq_ctrl
  import rot_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  localparam int SW = $clog2(WIDTH);

  state_e           state;
  state_e           state_nxt;
  op_e              op_q;
  op_e              op_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] amt;
  logic [CNT_W-1:0] dec;
  logic [WIDTH-1:0] res_nxt;
  logic             carry_nxt;
  logic             nib;
  logic [WIDTH-1:0] step_val;
  logic             step_c;

`ifdef ROT_SEQ_NIBBLE_STEP_EN
  assign nib = (cnt >= CNT_W'(4));
`else
  assign nib = 1'b0;
`endif

  assign dec       = nib ? CNT_W'(4) : CNT_W'(1);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign zero      = out_valid && (result == '0);

  rot_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .value      (result),
    .op         (op_q),
    .nib        (nib),
    .next_value (step_val),
    .carry_out  (step_c)
  );

  // effective amount: rotates wrap, shifts clamp at WIDTH
  always_comb begin
    amt = '0;
    if (op_e'(op) == OP_ROR || op_e'(op) == OP_ROL) begin
      amt = CNT_W'(b[SW-1:0]);
    end else if (b >= WIDTH'(WIDTH)) begin
      amt = CNT_W'(WIDTH);
    end else begin
      amt = CNT_W'(b);
    end
  end

  // next-state and datapath updates
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    cnt_nxt   = cnt;
    res_nxt   = result;
    carry_nxt = carry;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          op_nxt    = op_e'(op);
          res_nxt   = a;
          carry_nxt = 1'b0;
          cnt_nxt   = amt;
          state_nxt = (amt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_nxt   = step_val;
        carry_nxt = step_c;
        cnt_nxt   = cnt - dec;
        if (cnt == dec) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= OP_ROR;
      cnt    <= '0;
      result <= '0;
      carry  <= 1'b0;
    end else begin
      state  <= state_nxt;
      op_q   <= op_nxt;
      cnt    <= cnt_nxt;
      result <= res_nxt;
      carry  <= carry_nxt;
    end
  end

endmodule
